cumsum_stream_acc: RTL and testbench
====================================

Name: cumsum_stream_acc

Overview:
- Parametrised successor to the fixed 8-bit cumulative sum calculator.
- Accumulates a programmed count of N samples arriving over a valid/ready stream into a wide sum.
- Supports signed or unsigned operands, wrap or saturate on overflow, a sticky overflow flag, and restart while busy.
- Sits between the sample source and the result consumer in the data-clock domain.

Parameters:
DATA_W, 8, sample width in bits
CNT_W, 8, width of sample count N
SUM_W, 16, accumulator/result width; must be >= DATA_W
SIGNED, 0, 1 = data_in and sum are two's complement; 0 = unsigned
SATURATE, 0, 1 = clamp at range limit on overflow; 0 = modulo 2^SUM_W wrap

Ports:
clk_data  input  1  data clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  synchronous single-cycle command: load n_in, clear sum, begin run
n_in  input  CNT_W  sample count, sampled only when start=1
data_in  input  DATA_W  sample
data_valid  input  1  data_in valid this cycle
data_ready  output  1  block accepts a sample this cycle
busy  output  1  run in progress
done  output  1  run complete; held until next start
n_remaining  output  CNT_W  samples still to accept
sum_out  output  SUM_W  running/final sum
overflow  output  1  sticky: overflow occurred in current run

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0. Deassertion takes effect at the next rising edge.
- States: IDLE, ACCUM, DONE. All outputs are registered; no combinational path from inputs to outputs.
- data_ready = busy = (state==ACCUM).
- done = (state==DONE).
- start in any state (IDLE, ACCUM or DONE), next cycle:
  - sum_out=0, overflow=0, done=0, n_remaining=n_in.
  - State goes to ACCUM if n_in!=0.
  - State goes to DONE if n_in==0 (done=1, sum_out=0).
- start during ACCUM aborts the current run; a sample presented in the same cycle is discarded.
- ACCUM, accepted sample (data_valid & data_ready & !start):
  - sum_out <= sum_out + ext(data_in), where ext is sign-extension if SIGNED else zero-extension.
  - n_remaining decrements.
  - If n_remaining was 1: go to DONE; done=1 and data_ready=0 in the same cycle the final sum appears (latency 1 cycle from last accept).
- ACCUM, data_valid=0: hold all state; no timeout.
- data_valid while data_ready=0 is ignored; samples are never buffered.
- Arithmetic uses SUM_W+1 internal bits.
- Overflow detection:
  - Unsigned: carry out of SUM_W.
  - Signed: operands share a sign and the result sign differs.
- On overflow:
  - overflow <= 1, sticky until next start.
  - SATURATE=0: keep the low SUM_W bits (wrap).
  - SATURATE=1: clamp. Unsigned clamps to 2^SUM_W-1. Signed clamps to 2^(SUM_W-1)-1 or -2^(SUM_W-1) by direction.
  - Once saturated, further samples still apply; a sample of opposite sign moves the sum back off the limit.
- DONE: sum_out, n_remaining (=0) and overflow hold; done stays 1 until start or reset.
- Reset mid-run: immediate return to IDLE with all outputs 0; no result is produced.
- n_in = 2^CNT_W-1 is supported; the count never wraps.

Test Plan:
1. Default params; reset, start with n_in=4; samples 10,20,30,40 on consecutive cycles -> data_ready high 4 cycles; n_remaining 4,3,2,1,0; sum_out 10,30,60,100; done=1 the cycle sum=100; overflow=0.
2. Same run with data_valid gapped (valid every other cycle, junk data while valid=0) -> identical final sum 100; n_remaining holds during gaps; done only after 4th accept.
3. start with n_in=0 -> next cycle done=1, sum_out=0, busy=0; data_valid=1, data_in=55 afterwards -> no change.
4. SUM_W=8, SATURATE=0, n_in=2, samples 200,100 -> sum_out=44, overflow=1. Same stimulus with SATURATE=1 -> sum_out=255, overflow=1.
5. SIGNED=1, SATURATE=1, SUM_W=8, n_in=3, samples 0x64,0x64,0x9C (100,100,-100) -> sum 100, then 127 (overflow=1), then 27; overflow stays 1 at done.
6. Restart and reset:
   - n_in=5; after 2 samples (sum 30) assert start with n_in=2 alongside data_valid, data_in=7 -> 7 is discarded; sum_out=0, n_remaining=2; then samples 1,2 -> done, sum_out=3.
   - rst_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cumsum_stream_acc.sv
// cumsum_stream_acc: accumulates a programmed number of stream samples into a wide sum.
//
// A start command loads the sample count n_in and clears the sum. Samples are then
// accepted over a valid/ready handshake until the count is exhausted. Operands may be
// signed or unsigned. Overflow either wraps or saturates, and sets a sticky flag.
// A start issued in any state restarts the run.
//
// Ports:
//   clk_data     data clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle command: load n_in, clear sum, begin a run
//   n_in         sample count; sampled only while start=1
//   data_in      sample value
//   data_valid   data_in is valid this cycle
//   data_ready   a sample is accepted this cycle (equals busy)
//   busy         run in progress
//   done         run complete; held until the next start
//   n_remaining  samples still to accept
//   sum_out      running/final sum
//   overflow     sticky overflow flag for the current run
//
// All outputs are decoded from registered state, so there is no combinational
// path from any input to any output.

module cumsum_stream_acc #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SUM_W    = 16,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk_data,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  n_remaining,
    output logic [SUM_W-1:0]  sum_out,
    output logic              overflow
);

    // The extension of data_in below relies on the sum being at least as wide.
    if (SUM_W < DATA_W) begin : g_width_check
        $error("cumsum_stream_acc: SUM_W must be >= DATA_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;

    // Datapath: one extra bit holds the unsigned carry or the signed extension.
    logic [SUM_W:0]     sum_ext;
    logic [SUM_W:0]     data_ext;
    logic [SUM_W:0]     add_res;
    logic               add_ovf;
    logic [SUM_W-1:0]   sat_val;
    logic [SUM_W-1:0]   sum_next;

    always_comb begin
        if (SIGNED) begin
            sum_ext  = {sum_q[SUM_W-1], sum_q};
            data_ext = {{(SUM_W + 1 - DATA_W){data_in[DATA_W-1]}}, data_in};
        end else begin
            sum_ext  = {1'b0, sum_q};
            data_ext = {{(SUM_W + 1 - DATA_W){1'b0}}, data_in};
        end

        add_res = sum_ext + data_ext;

        if (SIGNED) begin
            // Same-sign operands whose result changes sign have left the range.
            add_ovf = (sum_q[SUM_W-1] == data_ext[SUM_W-1]) &&
                      (add_res[SUM_W-1] != sum_q[SUM_W-1]);
            // Direction of the overflow follows the sign of the sample.
            sat_val = data_ext[SUM_W] ? {1'b1, {(SUM_W - 1){1'b0}}}
                                      : {1'b0, {(SUM_W - 1){1'b1}}};
        end else begin
            add_ovf = add_res[SUM_W];
            sat_val = {SUM_W{1'b1}};
        end

        if (SATURATE && add_ovf) begin
            sum_next = sat_val;
        end else begin
            sum_next = add_res[SUM_W-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        if (start) begin
            // Restart from any state; a sample offered alongside start is dropped.
            cnt_d   = n_in;
            sum_d   = '0;
            ovf_d   = 1'b0;
            state_d = (n_in != '0) ? StAccum : StDone;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (data_valid) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        sum_d = sum_next;
                        if (add_ovf) begin
                            ovf_d = 1'b1;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StIdle,
                StDone: begin
                    // Hold until the next start.
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q == StAccum);
    assign data_ready  = busy;
    assign done        = (state_q == StDone);
    assign n_remaining = cnt_q;
    assign sum_out     = sum_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cumsum_stream_acc.sv
// Testbench for cumsum_stream_acc. Four instances share one stimulus stream:
//   d0: default parameters (unsigned, 16-bit sum, wrap)
//   d1: SUM_W=8, unsigned, wrap
//   d2: SUM_W=8, unsigned, saturate
//   d3: SUM_W=8, signed, saturate
// Inputs change 1 ns after a rising edge; outputs are read at that same point.

module tb_cumsum_stream_acc;

    logic       clk_data = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] n_in;
    logic [7:0] data_in;
    logic       data_valid;

    logic        d0_ready, d0_busy, d0_done, d0_ovf;
    logic [7:0]  d0_nrem;
    logic [15:0] d0_sum;
    logic        d1_ready, d1_busy, d1_done, d1_ovf;
    logic [7:0]  d1_nrem;
    logic [7:0]  d1_sum;
    logic        d2_ready, d2_busy, d2_done, d2_ovf;
    logic [7:0]  d2_nrem;
    logic [7:0]  d2_sum;
    logic        d3_ready, d3_busy, d3_done, d3_ovf;
    logic [7:0]  d3_nrem;
    logic [7:0]  d3_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk_data = ~clk_data;

    cumsum_stream_acc u_d0 (
        .clk_data    (clk_data),
        .rst_n       (rst_n),
        .start       (start),
        .n_in        (n_in),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (d0_ready),
        .busy        (d0_busy),
        .done        (d0_done),
        .n_remaining (d0_nrem),
        .sum_out     (d0_sum),
        .overflow    (d0_ovf)
    );

    cumsum_stream_acc #(.SUM_W(8), .SIGNED(1'b0), .SATURATE(1'b0)) u_d1 (
        .clk_data    (clk_data),
        .rst_n       (rst_n),
        .start       (start),
        .n_in        (n_in),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (d1_ready),
        .busy        (d1_busy),
        .done        (d1_done),
        .n_remaining (d1_nrem),
        .sum_out     (d1_sum),
        .overflow    (d1_ovf)
    );

    cumsum_stream_acc #(.SUM_W(8), .SIGNED(1'b0), .SATURATE(1'b1)) u_d2 (
        .clk_data    (clk_data),
        .rst_n       (rst_n),
        .start       (start),
        .n_in        (n_in),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (d2_ready),
        .busy        (d2_busy),
        .done        (d2_done),
        .n_remaining (d2_nrem),
        .sum_out     (d2_sum),
        .overflow    (d2_ovf)
    );

    cumsum_stream_acc #(.SUM_W(8), .SIGNED(1'b1), .SATURATE(1'b1)) u_d3 (
        .clk_data    (clk_data),
        .rst_n       (rst_n),
        .start       (start),
        .n_in        (n_in),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (d3_ready),
        .busy        (d3_busy),
        .done        (d3_done),
        .n_remaining (d3_nrem),
        .sum_out     (d3_sum),
        .overflow    (d3_ovf)
    );

    task automatic tick();
        @(posedge clk_data);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start      = 1'b1;
        n_in       = n;
        data_valid = 1'b0;
        tick();
        start      = 1'b0;
    endtask

    // Reset state, then a clean release.
    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        n_in       = '0;
        data_in    = '0;
        data_valid = 1'b0;
        #23;
        checks++;
        if ({d0_ready, d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum} !== 28'h0) begin
            errors++;
            $display("FAIL reset_d0: got %h expected 0",
                     {d0_ready, d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum});
        end
        @(negedge clk_data);
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum} !== 27'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0",
                     {d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum});
        end
    endtask

    // Four samples on consecutive cycles.
    task automatic test_basic();
        logic [7:0]  vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        logic [15:0] sums [4] = '{16'd10, 16'd30, 16'd60, 16'd100};
        do_start(8'd4);
        checks++;
        if ({d0_ready, d0_busy, d0_done, d0_nrem, d0_sum} !== {3'b110, 8'd4, 16'd0}) begin
            errors++;
            $display("FAIL basic_start: got rdy/busy/done=%b nrem=%0d sum=%0d expected 110 4 0",
                     {d0_ready, d0_busy, d0_done}, d0_nrem, d0_sum);
        end
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1;
            data_in    = vals[i];
            tick();
            checks++;
            if (d0_nrem !== 8'(3 - i) || d0_sum !== sums[i] || d0_done !== (i == 3) ||
                d0_ready !== (i != 3)) begin
                errors++;
                $display("FAIL basic_step%0d: got nrem=%0d sum=%0d done=%b rdy=%b expected %0d %0d %b %b",
                         i, d0_nrem, d0_sum, d0_done, d0_ready, 3 - i, sums[i], i == 3, i != 3);
            end
        end
        data_valid = 1'b0;
        checks++;
        if (d0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b expected 0", d0_ovf);
        end
    endtask

    // Same run with a gap cycle and junk data between samples.
    task automatic test_gapped();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1;
            data_in    = vals[i];
            tick();
            data_valid = 1'b0;
            data_in    = 8'hA5;
            tick();
            checks++;
            if (d0_nrem !== 8'(3 - i) || d0_done !== (i == 3)) begin
                errors++;
                $display("FAIL gap_hold%0d: got nrem=%0d done=%b expected %0d %b",
                         i, d0_nrem, d0_done, 3 - i, i == 3);
            end
        end
        checks++;
        if (d0_sum !== 16'd100 || d0_done !== 1'b1) begin
            errors++;
            $display("FAIL gap_final: got sum=%0d done=%b expected 100 1", d0_sum, d0_done);
        end
    endtask

    // Zero-length run goes straight to done and ignores later samples.
    task automatic test_zero_count();
        do_start(8'd0);
        checks++;
        if ({d0_done, d0_busy, d0_ready} !== 3'b100 || d0_sum !== 16'd0) begin
            errors++;
            $display("FAIL zero_done: got done/busy/rdy=%b sum=%0d expected 100 0",
                     {d0_done, d0_busy, d0_ready}, d0_sum);
        end
        data_valid = 1'b1;
        data_in    = 8'd55;
        tick();
        tick();
        data_valid = 1'b0;
        checks++;
        if (d0_done !== 1'b1 || d0_sum !== 16'd0 || d0_nrem !== 8'd0) begin
            errors++;
            $display("FAIL zero_ignore: got done=%b sum=%0d nrem=%0d expected 1 0 0",
                     d0_done, d0_sum, d0_nrem);
        end
    endtask

    // 200 + 100 in an 8-bit sum: wraps to 44 or saturates to 255.
    task automatic test_unsigned_overflow();
        do_start(8'd2);
        data_valid = 1'b1;
        data_in    = 8'd200;
        tick();
        data_in    = 8'd100;
        tick();
        data_valid = 1'b0;
        checks++;
        if (d1_sum !== 8'd44 || d1_ovf !== 1'b1 || d1_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got sum=%0d ovf=%b done=%b expected 44 1 1",
                     d1_sum, d1_ovf, d1_done);
        end
        checks++;
        if (d2_sum !== 8'd255 || d2_ovf !== 1'b1 || d2_done !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got sum=%0d ovf=%b done=%b expected 255 1 1",
                     d2_sum, d2_ovf, d2_done);
        end
        checks++;
        if (d0_sum !== 16'd300 || d0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wide_no_ovf: got sum=%0d ovf=%b expected 300 0", d0_sum, d0_ovf);
        end
    endtask

    // Signed saturate: 100, 100, -100 -> 100, 127 (overflow), 27.
    task automatic test_signed_saturate();
        logic [7:0] vals [3] = '{8'h64, 8'h64, 8'h9C};
        logic [7:0] sums [3] = '{8'd100, 8'd127, 8'd27};
        logic       ovfs [3] = '{1'b0, 1'b1, 1'b1};
        do_start(8'd3);
        checks++;
        if (d1_ovf !== 1'b0 || d1_sum !== 8'd0) begin
            errors++;
            $display("FAIL start_clears_ovf: got ovf=%b sum=%0d expected 0 0", d1_ovf, d1_sum);
        end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = vals[i];
            tick();
            checks++;
            if (d3_sum !== sums[i] || d3_ovf !== ovfs[i]) begin
                errors++;
                $display("FAIL signed_step%0d: got sum=%0d ovf=%b expected %0d %b",
                         i, d3_sum, d3_ovf, sums[i], ovfs[i]);
            end
        end
        data_valid = 1'b0;
        tick();
        checks++;
        if (d3_done !== 1'b1 || d3_ovf !== 1'b1 || d3_sum !== 8'd27) begin
            errors++;
            $display("FAIL signed_done: got done=%b ovf=%b sum=%0d expected 1 1 27",
                     d3_done, d3_ovf, d3_sum);
        end
    endtask

    // Restart mid-run discards the concurrent sample.
    task automatic test_restart();
        do_start(8'd5);
        data_valid = 1'b1;
        data_in    = 8'd10;
        tick();
        data_in    = 8'd20;
        tick();
        checks++;
        if (d0_sum !== 16'd30 || d0_nrem !== 8'd3) begin
            errors++;
            $display("FAIL restart_pre: got sum=%0d nrem=%0d expected 30 3", d0_sum, d0_nrem);
        end
        start   = 1'b1;
        n_in    = 8'd2;
        data_in = 8'd7;
        tick();
        start   = 1'b0;
        checks++;
        if (d0_sum !== 16'd0 || d0_nrem !== 8'd2 || d0_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_load: got sum=%0d nrem=%0d busy=%b expected 0 2 1",
                     d0_sum, d0_nrem, d0_busy);
        end
        data_in = 8'd1;
        tick();
        data_in = 8'd2;
        tick();
        data_valid = 1'b0;
        checks++;
        if (d0_sum !== 16'd3 || d0_done !== 1'b1 || d0_nrem !== 8'd0) begin
            errors++;
            $display("FAIL restart_final: got sum=%0d done=%b nrem=%0d expected 3 1 0",
                     d0_sum, d0_done, d0_nrem);
        end
    endtask

    // Asynchronous reset mid-run clears everything without a clock edge.
    task automatic test_reset_mid_run();
        do_start(8'd5);
        data_valid = 1'b1;
        data_in    = 8'd10;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d0_ready, d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {d0_ready, d0_busy, d0_done, d0_ovf, d0_nrem, d0_sum});
        end
        data_valid = 1'b0;
        @(negedge clk_data);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({d0_busy, d0_done, d0_nrem, d0_sum} !== 26'h0) begin
            errors++;
            $display("FAIL reset_no_result: got %h expected 0",
                     {d0_busy, d0_done, d0_nrem, d0_sum});
        end
    endtask

    // Largest count runs to completion without wrapping.
    task automatic test_max_count();
        do_start(8'd255);
        data_valid = 1'b1;
        data_in    = 8'd1;
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        checks++;
        if (d0_done !== 1'b0 || d0_nrem !== 8'd1 || d0_sum !== 16'd254) begin
            errors++;
            $display("FAIL max_before_last: got done=%b nrem=%0d sum=%0d expected 0 1 254",
                     d0_done, d0_nrem, d0_sum);
        end
        tick();
        tick();
        data_valid = 1'b0;
        checks++;
        if (d0_done !== 1'b1 || d0_nrem !== 8'd0 || d0_sum !== 16'd255 ||
            d1_sum !== 8'd255 || d1_ovf !== 1'b0) begin
            errors++;
            $display("FAIL max_final: got done=%b nrem=%0d sum=%0d sum8=%0d ovf8=%b expected 1 0 255 255 0",
                     d0_done, d0_nrem, d0_sum, d1_sum, d1_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_zero_count();
        test_unsigned_overflow();
        test_signed_saturate();
        test_restart();
        test_reset_mid_run();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
